write_split_resp_merge: RTL and testbench
=========================================

# write_split_resp_merge

Merges the write responses (B) of split bursts back into one response per original master burst. It sits between one slave's B channel and the write response controller, directly upstream of it. It also drives that controller's split status: remaining count, completed count and split flag. Split descriptors are queued from the address splitter.

## Interface
Parameters:
- NUM_MASTERS, 2, number of masters; sets BID_W
- BID_W, $clog2(NUM_MASTERS), B ID width
- DEPTH, 4, descriptor FIFO entries (power of two, ≥2)
- CNT_W, 4, sub-burst count width

Ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- split_valid  in  1  descriptor offered by address splitter
- split_ready  out  1  descriptor accepted
- split_bid  in  BID_W  master ID of original burst
- split_cnt  in  CNT_W  number of sub-bursts (1..15; 0 treated as 1)
- m_bid  in  BID_W  slave B ID
- m_bresp  in  2  slave B response
- m_bvalid  in  1  slave B valid
- m_bready  out  1  slave B ready
- s_bid  out  BID_W  merged B ID to response controller
- s_bresp  out  2  merged response
- s_bvalid  out  1  merged valid
- s_bready  in  1  merged ready
- Rem  out  CNT_W  sub-responses still outstanding for head burst
- Num_Of_Compl_Bursts  out  CNT_W  sub-responses received for head burst
- Is_Master_Part_Of_Split  out  1  head descriptor has cnt > 1
- bid_err  out  1  sticky ID mismatch flag (macro-dependent)

## Operation
- Descriptor FIFO {bid, cnt}, DEPTH entries. Push on split_valid && split_ready. Pop when the merged response handshakes on s_*.
- The slave returns B responses in issue order. Sub-responses bind to the FIFO head.
- FSM:
  - IDLE: FIFO empty; m_bready=0; → COLLECT when FIFO is non-empty.
  - COLLECT: m_bready=1. Each m_bvalid && m_bready increments Num_Of_Compl_Bursts, decrements Rem and merges the response. When the last sub-response is accepted (Rem==1) → RESP.
  - RESP: s_bvalid=1 with s_bid = head bid and s_bresp = merged value; m_bready=0. On s_bready: pop the FIFO, clear counters and merge state. → COLLECT if ≥1 entry remains after the pop, else IDLE.
- Merge rule, priority DECERR(3) > SLVERR(2) > OKAY(0) > EXOKAY(1):
  - EXOKAY survives only if every sub-response was EXOKAY.
  - Any OKAY or error downgrades EXOKAY.
- Rem is loaded with the head's cnt on entry to COLLECT. Num_Of_Compl_Bursts counts up from 0.
- Is_Master_Part_Of_Split = (head cnt > 1) while the FIFO is non-empty, else 0.
- cnt==1 behaves as a pass-through with one register stage.

## Timing
- Reset values: split_ready=1, m_bready=0, s_bvalid=0, s_bid=0, s_bresp=0, Rem=0, Num_Of_Compl_Bursts=0, Is_Master_Part_Of_Split=0, bid_err=0. State=IDLE, FIFO empty.
- split_ready = !full, registered from the current count. A push is refused when full, even in the cycle a pop occurs.
- Push to an empty FIFO: COLLECT and m_bready=1 in the next cycle. Rem is valid in the same cycle.
- Last sub-response accepted in cycle N → s_bvalid=1 in cycle N+1.
- s_bid and s_bresp stay stable while s_bvalid && !s_bready.
- Pop in cycle N with the next entry present → m_bready=1 in cycle N+1. Back-to-back bursts cost one bubble cycle.
- Counters never wrap: Num_Of_Compl_Bursts ≤ cnt ≤ 15.
- Reset asserted mid-burst discards all descriptors and partial merges. Outputs return to their reset values immediately (asynchronous).

## Configuration
- WRITE_SPLIT_RESP_MERGE_BID_CHECK_EN defined:
  - Each accepted m_bid is compared against the head bid.
  - A mismatch forces the merged response to at least SLVERR and sets bid_err.
  - bid_err stays set until reset.
- Undefined: no comparison is made, m_bid is ignored, and bid_err is tied to 0.

## Structure
- Shared package holds:
  - bresp encodings (OKAY, EXOKAY, SLVERR, DECERR)
  - the merge-priority function
  - the FSM state enum {IDLE, COLLECT, RESP}
  - the descriptor struct {bid, cnt}
- One sub-module: write_split_desc_fifo (parameterized DEPTH and width, full/empty/count). The FSM and merge logic live in the top module.

## Test plan
- Single descriptor bid=1, cnt=1; slave returns OKAY → one s_* response bid=1 OKAY, one cycle after m handshake. Rem goes 1→0.
- bid=0, cnt=3; sub-responses OKAY, SLVERR, OKAY → exactly one s_bresp=2. Num_Of_Compl_Bursts steps 0,1,2,3. Is_Master_Part_Of_Split=1 throughout.
- cnt=2: both EXOKAY → s_bresp=1. Repeat with EXOKAY then OKAY → s_bresp=0.
- Push 4 descriptors with no responses → split_ready=0 after the fourth push. Drain while holding s_bready low for 5 cycles → s_* stays stable and m_bready=0 during the hold.
- With BID_CHECK_EN, head bid=1 and m_bid=0 with OKAY → s_bresp=2 and bid_err=1 sticky. Without the macro → s_bresp=0 and bid_err=0.
- Assert reset_n low with 2 of 3 sub-responses received → all outputs at reset values. After release, a fresh cnt=1 descriptor completes normally.

Source files
------------

// File: rtl/write_split_resp_merge_pkg.sv
// Shared types and helpers for the split-burst write response merger:
// bresp encodings, merge priority, FSM states and the split descriptor.
package write_split_resp_merge_pkg;

  localparam int unsigned DefNumMasters = 2;
  localparam int unsigned DescBidW      = $clog2(DefNumMasters);
  localparam int unsigned DescCntW      = 4;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StResp
  } merge_state_e;

  typedef struct packed {
    logic [DescBidW-1:0] bid;
    logic [DescCntW-1:0] cnt;
  } split_desc_t;

  // Higher rank wins; EXOKAY is the weakest so it is the merge identity.
  function automatic logic [1:0] resp_rank(input logic [1:0] resp);
    logic [1:0] rank;
    case (resp)
      RespDecErr: rank = 2'd3;
      RespSlvErr: rank = 2'd2;
      RespOkay:   rank = 2'd1;
      default:    rank = 2'd0;
    endcase
    return rank;
  endfunction

  function automatic logic [1:0] merge_resp(input logic [1:0] a, input logic [1:0] b);
    return (resp_rank(a) >= resp_rank(b)) ? a : b;
  endfunction

endpackage

// File: rtl/write_split_desc_fifo.sv
// Small synchronous FIFO holding split descriptors; exposes head data,
// full/empty and the current fill count. Depth must be a power of two.
module write_split_desc_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CountW = $clog2(Depth + 1);

  logic [Width-1:0]  mem_q [Depth];
  logic [Width-1:0]  mem_d [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CountW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Overflow/underflow requests are silently dropped.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CountW'(1);
      2'b01:   count_d = count_q - CountW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed through count_q.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/write_split_resp_merge.sv
// Merges B responses of split sub-bursts into one response per master burst
// and reports split status. Optional ID check: WRITE_SPLIT_RESP_MERGE_BID_CHECK_EN.
module write_split_resp_merge
  import write_split_resp_merge_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DefNumMasters,
  parameter int unsigned BID_W       = $clog2(NUM_MASTERS),
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned CNT_W       = DescCntW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             split_valid,
  output logic             split_ready,
  input  logic [BID_W-1:0] split_bid,
  input  logic [CNT_W-1:0] split_cnt,
  input  logic [BID_W-1:0] m_bid,
  input  logic [1:0]       m_bresp,
  input  logic             m_bvalid,
  output logic             m_bready,
  output logic [BID_W-1:0] s_bid,
  output logic [1:0]       s_bresp,
  output logic             s_bvalid,
  input  logic             s_bready,
  output logic [CNT_W-1:0] Rem,
  output logic [CNT_W-1:0] Num_Of_Compl_Bursts,
  output logic             Is_Master_Part_Of_Split,
  output logic             bid_err
);

  localparam int unsigned DescW  = $bits(split_desc_t);
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  merge_state_e      state_q, state_d;
  logic [CNT_W-1:0]  compl_q, compl_d;
  logic [1:0]        acc_q, acc_d;

  split_desc_t       push_desc, head_desc;
  logic [DescW-1:0]  fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CountW-1:0] fifo_count;
  logic              push, pop;

  logic              beat_fire, beat_err;
  logic [1:0]        beat_resp;
  logic [CNT_W-1:0]  rem;

  // A zero count is treated as a single, unsplit burst.
  always_comb begin
    push_desc.bid = split_bid;
    push_desc.cnt = (split_cnt == '0) ? CNT_W'(1) : split_cnt;
  end

  assign split_ready = !fifo_full;
  assign push        = split_valid && !fifo_full;

  write_split_desc_fifo #(
    .Depth(DEPTH),
    .Width(DescW)
  ) u_desc_fifo (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .push_i (push),
    .data_i (push_desc),
    .pop_i  (pop),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  assign head_desc = split_desc_t'(fifo_rdata);

  // Outstanding count follows the head directly, so it is valid as soon as
  // the descriptor lands in the FIFO.
  assign rem       = fifo_empty ? '0 : (head_desc.cnt - compl_q);
  assign beat_fire = (state_q == StCollect) && m_bvalid;

`ifdef WRITE_SPLIT_RESP_MERGE_BID_CHECK_EN
  logic bid_err_q, bid_err_d;

  assign beat_err  = (m_bid != head_desc.bid);
  assign bid_err_d = bid_err_q | (beat_fire & beat_err);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bid_err_q <= 1'b0;
    end else begin
      bid_err_q <= bid_err_d;
    end
  end

  assign bid_err = bid_err_q;
`else
  logic unused_m_bid;

  assign unused_m_bid = ^m_bid;
  assign beat_err     = 1'b0;
  assign bid_err      = 1'b0;
`endif

  assign beat_resp = beat_err ? merge_resp(m_bresp, RespSlvErr) : m_bresp;

  always_comb begin
    state_d = state_q;
    compl_d = compl_q;
    acc_d   = acc_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (push || !fifo_empty) begin
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (m_bvalid) begin
          compl_d = compl_q + CNT_W'(1);
          acc_d   = merge_resp(acc_q, beat_resp);
          if (rem == CNT_W'(1)) begin
            state_d = StResp;
          end
        end
      end
      StResp: begin
        if (s_bready) begin
          pop     = 1'b1;
          compl_d = '0;
          acc_d   = RespExOkay;
          // A push is never accepted while full, so only count>1 or a fresh
          // push can leave work behind after this pop.
          state_d = ((fifo_count > CountW'(1)) || push) ? StCollect : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      compl_q <= '0;
      acc_q   <= RespExOkay;
    end else begin
      state_q <= state_d;
      compl_q <= compl_d;
      acc_q   <= acc_d;
    end
  end

  assign m_bready                = (state_q == StCollect);
  assign s_bvalid                = (state_q == StResp);
  assign s_bid                   = s_bvalid ? head_desc.bid : '0;
  assign s_bresp                 = s_bvalid ? acc_q : RespOkay;
  assign Rem                     = rem;
  assign Num_Of_Compl_Bursts     = compl_q;
  assign Is_Master_Part_Of_Split = !fifo_empty && (head_desc.cnt > CNT_W'(1));

endmodule

// File: tb/tb_write_split_resp_merge.sv
// Directed self-checking bench for write_split_resp_merge (default widths).
module tb_write_split_resp_merge;

  localparam int unsigned BidW = 1;
  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            split_valid;
  logic            split_ready;
  logic [BidW-1:0] split_bid;
  logic [CntW-1:0] split_cnt;
  logic [BidW-1:0] m_bid;
  logic [1:0]      m_bresp;
  logic            m_bvalid;
  logic            m_bready;
  logic [BidW-1:0] s_bid;
  logic [1:0]      s_bresp;
  logic            s_bvalid;
  logic            s_bready;
  logic [CntW-1:0] rem;
  logic [CntW-1:0] num_compl;
  logic            is_split;
  logic            bid_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  write_split_resp_merge dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .split_valid            (split_valid),
    .split_ready            (split_ready),
    .split_bid              (split_bid),
    .split_cnt              (split_cnt),
    .m_bid                  (m_bid),
    .m_bresp                (m_bresp),
    .m_bvalid               (m_bvalid),
    .m_bready               (m_bready),
    .s_bid                  (s_bid),
    .s_bresp                (s_bresp),
    .s_bvalid               (s_bvalid),
    .s_bready               (s_bready),
    .Rem                    (rem),
    .Num_Of_Compl_Bursts    (num_compl),
    .Is_Master_Part_Of_Split(is_split),
    .bid_err                (bid_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_split_ready"}, 32'(split_ready), 1);
    check({tag, "_m_bready"}, 32'(m_bready), 0);
    check({tag, "_s_bvalid"}, 32'(s_bvalid), 0);
    check({tag, "_s_bid"}, 32'(s_bid), 0);
    check({tag, "_s_bresp"}, 32'(s_bresp), 0);
    check({tag, "_rem"}, 32'(rem), 0);
    check({tag, "_num"}, 32'(num_compl), 0);
    check({tag, "_is_split"}, 32'(is_split), 0);
    check({tag, "_bid_err"}, 32'(bid_err), 0);
  endtask

  // One complete burst starting from IDLE; rs packs sub-responses LSB first.
  task automatic burst(input string tag, input logic [BidW-1:0] bid, input int n,
                       input logic [5:0] rs, input logic [BidW-1:0] mbid,
                       input logic [1:0] exp_resp);
    split_valid = 1'b1;
    split_bid   = bid;
    split_cnt   = CntW'(n);
    tick();
    split_valid = 1'b0;
    check({tag, "_m_bready_start"}, 32'(m_bready), 1);
    for (int i = 0; i < n; i++) begin
      check({tag, "_rem"}, 32'(rem), 32'(n - i));
      check({tag, "_num"}, 32'(num_compl), 32'(i));
      check({tag, "_is_split"}, 32'(is_split), (n > 1) ? 1 : 0);
      check({tag, "_s_bvalid_early"}, 32'(s_bvalid), 0);
      m_bvalid = 1'b1;
      m_bid    = mbid;
      m_bresp  = rs[2*i +: 2];
      tick();
      m_bvalid = 1'b0;
    end
    check({tag, "_s_bvalid"}, 32'(s_bvalid), 1);
    check({tag, "_s_bid"}, 32'(s_bid), 32'(bid));
    check({tag, "_s_bresp"}, 32'(s_bresp), 32'(exp_resp));
    check({tag, "_rem_done"}, 32'(rem), 0);
    check({tag, "_num_done"}, 32'(num_compl), 32'(n));
    check({tag, "_m_bready_resp"}, 32'(m_bready), 0);
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    check({tag, "_s_bvalid_after"}, 32'(s_bvalid), 0);
    check({tag, "_m_bready_after"}, 32'(m_bready), 0);
  endtask

  initial begin
    reset_n     = 1'b0;
    split_valid = 1'b0;
    split_bid   = '0;
    split_cnt   = '0;
    m_bid       = '0;
    m_bresp     = 2'b00;
    m_bvalid    = 1'b0;
    s_bready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_hold");
    reset_n = 1'b1;
    tick();
    check_reset("rst_rel");

    // Single pass-through and a 3-way split with an error in the middle.
    burst("t1", 1'b1, 1, 6'b00_00_00, 1'b1, 2'd0);
    burst("t2", 1'b0, 3, 6'b00_10_00, 1'b0, 2'd2);
    // EXOKAY survives only when unanimous.
    burst("t3a", 1'b1, 2, 6'b00_01_01, 1'b1, 2'd1);
    burst("t3b", 1'b1, 2, 6'b00_00_01, 1'b1, 2'd0);

    // Fill the FIFO, then a refused push while full.
    for (int i = 0; i < 4; i++) begin
      check("t4_ready_fill", 32'(split_ready), 1);
      split_valid = 1'b1;
      split_bid   = BidW'(i % 2);
      split_cnt   = CntW'(1);
      tick();
    end
    split_valid = 1'b0;
    check("t4_full", 32'(split_ready), 0);
    split_valid = 1'b1;
    split_bid   = 1'b1;
    split_cnt   = CntW'(2);
    tick();
    split_valid = 1'b0;
    check("t4_still_full", 32'(split_ready), 0);

    // Head response with s_bready held low.
    m_bvalid = 1'b1;
    m_bid    = 1'b0;
    m_bresp  = 2'd2;
    tick();
    m_bvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(s_bvalid), 1);
      check("t4_hold_bid", 32'(s_bid), 0);
      check("t4_hold_resp", 32'(s_bresp), 2);
      check("t4_hold_m_bready", 32'(m_bready), 0);
      tick();
    end
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    check("t4_pop_m_bready", 32'(m_bready), 1);
    check("t4_pop_s_bvalid", 32'(s_bvalid), 0);
    check("t4_pop_ready", 32'(split_ready), 1);
    for (int k = 1; k < 4; k++) begin
      m_bvalid = 1'b1;
      m_bid    = BidW'(k % 2);
      m_bresp  = 2'd0;
      tick();
      m_bvalid = 1'b0;
      check("t4_drain_valid", 32'(s_bvalid), 1);
      check("t4_drain_bid", 32'(s_bid), 32'(k % 2));
      check("t4_drain_resp", 32'(s_bresp), 0);
      s_bready = 1'b1;
      tick();
      s_bready = 1'b0;
      check("t4_drain_m_bready", 32'(m_bready), (k < 3) ? 1 : 0);
    end
    check("t4_empty_is_split", 32'(is_split), 0);

    // ID mismatch: head bid 1, slave returns bid 0 with OKAY.
`ifdef WRITE_SPLIT_RESP_MERGE_BID_CHECK_EN
    burst("t5", 1'b1, 1, 6'b00_00_00, 1'b0, 2'd2);
    check("t5_bid_err", 32'(bid_err), 1);
    burst("t5b", 1'b0, 1, 6'b00_00_01, 1'b0, 2'd1);
    check("t5b_bid_err_sticky", 32'(bid_err), 1);
`else
    burst("t5", 1'b1, 1, 6'b00_00_00, 1'b0, 2'd0);
    check("t5_bid_err", 32'(bid_err), 0);
    burst("t5b", 1'b0, 1, 6'b00_00_01, 1'b0, 2'd1);
    check("t5b_bid_err", 32'(bid_err), 0);
`endif

    // Reset mid-burst after 2 of 3 sub-responses.
    split_valid = 1'b1;
    split_bid   = 1'b1;
    split_cnt   = CntW'(3);
    tick();
    split_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_bvalid = 1'b1;
      m_bid    = 1'b1;
      m_bresp  = 2'd2;
      tick();
    end
    m_bvalid = 1'b0;
    check("t6_mid_num", 32'(num_compl), 2);
    check("t6_mid_rem", 32'(rem), 1);
    reset_n = 1'b0;
    #2;
    check_reset("t6_async");
    reset_n = 1'b1;
    tick();
    check_reset("t6_rel");
    burst("t6_fresh", 1'b1, 1, 6'b00_00_00, 1'b1, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
